// File: rtl/cep_backdoor_pkg.sv
// Shared types for the scratchpad backdoor arbiter: FSM states, command record,
// default bus widths and the doubleword address alignment helper.
package cep_backdoor_pkg;

    localparam int BD_ADDR_W = 32;
    localparam int BD_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } bd_state_e;

    typedef struct packed {
        logic                 write;
        logic [BD_ADDR_W-1:0] addr;
        logic [BD_DATA_W-1:0] wdata;
    } bd_cmd_t;

    // The scratchpad is doubleword addressed; the low byte-offset bits never reach it.
    function automatic logic [BD_ADDR_W-1:0] bd_align(input logic [BD_ADDR_W-1:0] a);
        return {a[BD_ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/mainmem_backdoor_arbiter_if.sv
// Requester and scratchpad-side signals of the backdoor arbiter.
// slave = the arbiter's view, master = the requesters plus memory driving it.
interface mainmem_backdoor_arbiter_if
    import cep_backdoor_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = BD_ADDR_W,
    parameter int DATA_W  = BD_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      mem_ready;
    logic                      mem_write;
    logic [DATA_W/8-1:0]       mem_mask;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_write, mem_mask, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_write, mem_mask, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/bd_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Zero latency; grant is all zeros when no request is pending.
module bd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + 32'(k)) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mainmem_backdoor_arbiter.sv
// Round-robin owner of the single scratchpad port; one 64-bit access in flight.
// Write responds 2 cycles after accept, read 3; requests wait while busy or mem_ready=0.
module mainmem_backdoor_arbiter
    import cep_backdoor_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = BD_ADDR_W,
    parameter int DATA_W  = BD_DATA_W
) (
    input logic                        clk,
    input logic                        rstn,
    mainmem_backdoor_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    bd_state_e          state_q, state_d;
    bd_cmd_t            cmd_q, cmd_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   win;
    logic               accept;
    logic [NUM_REQ-1:0] rsp_vec;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    bd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (win)
    );

    // Gating with rstn keeps req_ready low while reset is held.
    assign accept = rstn && (state_q == IDLE) && bus.mem_ready && (|bus.req_valid);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d       = win;
                    cmd_d.write   = bus.req_write[win];
                    cmd_d.addr    = addr_a[win];
                    cmd_d.wdata   = wdata_a[win];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    if (cmd_q.write) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Data read while the memory dropped ready is untrusted: issue the read again.
                if (!bus.mem_ready) begin
                    state_d = ISSUE;
                end else begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        rsp_vec = '0;
        if (state_q == RESP) rsp_vec[owner_q] = 1'b1;
    end

    assign bus.req_ready = accept ? gnt : '0;
    assign bus.rsp_valid = rsp_vec;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = (state_q == RESP) && (cmd_q.addr[2:0] != 3'b000);
    assign bus.mem_write = (state_q == ISSUE) && cmd_q.write && bus.mem_ready;
    assign bus.mem_mask  = ((state_q == ISSUE) && cmd_q.write) ? '1 : '0;
    assign bus.mem_addr  = bd_align(cmd_q.addr);
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mainmem_backdoor_arbiter.sv
// Bench for mainmem_backdoor_arbiter: directed scenarios plus random traffic against
// a transaction-level model (rr order, fixed response latencies, word memory image).
module tb_mainmem_backdoor_arbiter;

    localparam int NR = 4;

    logic clk;
    logic rstn;

    mainmem_backdoor_arbiter_if #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(64)) bus ();

    mainmem_backdoor_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0] p_vld;
    logic [NR-1:0] p_wr;
    logic [31:0]   p_addr [NR];
    logic [63:0]   p_wd   [NR];

    assign bus.req_valid = p_vld;
    assign bus.req_write = p_wr;
    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign bus.req_addr[g*32 +: 32]  = p_addr[g];
        assign bus.req_wdata[g*64 +: 64] = p_wd[g];
    end

    // Scratchpad: one-cycle write, registered read; garbage returned while not ready.
    logic [63:0] phys [64] = '{default: 64'h0};
    always @(posedge clk) begin
        if (bus.mem_write) phys[bus.mem_addr[8:3]] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_ready ? phys[bus.mem_addr[8:3]] : ~phys[bus.mem_addr[8:3]];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mm [64];
    int          cyc;
    int          m_ptr;
    bit          t_act;
    int          t_acc;
    logic [1:0]  t_owner;
    bit          t_wr;
    logic [31:0] t_addr;
    logic [63:0] t_wd;
    bit          acc [NR];
    int          gq [$];
    int          rlog_owner [$];
    logic [63:0] rlog_data [$];
    logic        rlog_err [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: compares the cycle's outputs with the model, then
    // decides which requester (if any) the rising edge should accept.
    task automatic mon();
        logic [NR-1:0] exp_gnt;
        logic [NR-1:0] exp_rv;
        logic          exp_wr;
        logic [1:0]    w;
        logic [1:0]    idx;
        bit            found;
        bit            free;
        free    = !t_act;
        exp_gnt = '0;
        exp_rv  = '0;
        exp_wr  = 1'b0;
        found   = 1'b0;
        w       = '0;
        chk("busy", 64'(bus.busy), 64'(t_act));
        if (t_act && cyc == t_acc + 1) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'({t_addr[31:3], 3'b000}));
            if (t_wr) chk("mem_wdata", bus.mem_wdata, t_wd);
            exp_wr = t_wr;
        end
        chk("mem_write", 64'(bus.mem_write), 64'(exp_wr));
        chk("mem_mask", 64'(bus.mem_mask), exp_wr ? 64'hFF : 64'h0);
        if (t_act && cyc == t_acc + (t_wr ? 2 : 3)) begin
            exp_rv[t_owner] = 1'b1;
            chk("rsp_err", 64'(bus.rsp_err), 64'(t_addr[2:0] != 3'b000));
            chk("rsp_rdata", bus.rsp_rdata, t_wr ? 64'h0 : mm[t_addr[8:3]]);
            rlog_owner.push_back(int'(t_owner));
            rlog_data.push_back(bus.rsp_rdata);
            rlog_err.push_back(bus.rsp_err);
            t_act = 1'b0;
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (free && bus.mem_ready) begin
            for (int k = 0; k < NR; k++) begin
                idx = 2'((m_ptr + k) % NR);
                if (!found && p_vld[idx]) begin
                    found = 1'b1;
                    w     = idx;
                end
            end
        end
        if (found) exp_gnt[w] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
        if (found) begin
            t_act   = 1'b1;
            t_acc   = cyc;
            t_owner = w;
            t_wr    = p_wr[w];
            t_addr  = p_addr[w];
            t_wd    = p_wd[w];
            if (p_wr[w]) mm[p_addr[w][8:3]] = p_wd[w];
            m_ptr   = (int'(w) + 1) % NR;
            gq.push_back(int'(w));
            acc[w]  = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                p_vld[i] = 1'b0;
                acc[i]   = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        bus.mem_ready = 1'b1;
        while (n < budget && (t_act || p_vld != '0)) begin
            step();
            n++;
        end
        chk(tag, 64'(t_act || p_vld != '0), 64'h0);
    endtask

    task automatic model_reset();
        t_act = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) acc[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [63:0] d);
        p_vld[i]  = 1'b1;
        p_wr[i]   = wr;
        p_addr[i] = a;
        p_wd[i]   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gb;
        bit          rereq;
        int          n;
        int          exp_order [5];
        logic [63:0] exp5, got5, wd4;
        int          acc_c, rsp_c, rsp_n, other;
        bit          seen;

        rstn  = 1'b0;
        p_vld = '0;
        p_wr  = '0;
        for (int i = 0; i < NR; i++) begin
            p_addr[i] = '0;
            p_wd[i]   = '0;
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 64; i++) mm[i] = 64'h0;
        cyc = 0;
        model_reset();

        // Reset values
        #12;
        chk("rst_busy",      64'(bus.busy),      64'h0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      64'h0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'h0);
        chk("rst_mem_write", 64'(bus.mem_write), 64'h0);
        chk("rst_mem_mask",  64'(bus.mem_mask),  64'h0);
        chk("rst_mem_addr",  64'(bus.mem_addr),  64'h0);
        chk("rst_mem_wdata", bus.mem_wdata,      64'h0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single write from requester 0
        set_req(0, 1'b1, 32'h1000, 64'hDEAD_BEEF_CAFE_F00D);
        drain("t1_timeout", 20);
        chk("t1_owner", 64'(rlog_owner[$]), 64'd0);
        chk("t1_err",   64'(rlog_err[$]),   64'h0);
        chk("t1_mem",   phys[0],            64'hDEAD_BEEF_CAFE_F00D);

        // Read-back from requester 1
        set_req(1, 1'b0, 32'h1000, 64'h0);
        drain("t2_timeout", 20);
        chk("t2_owner", 64'(rlog_owner[$]), 64'd1);
        chk("t2_data",  rlog_data[$],       64'hDEAD_BEEF_CAFE_F00D);

        // Contention straight out of reset; requester 0 comes back after its grant
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        set_req(0, 1'b1, 32'h1008, 64'h0123_4567_89AB_CDEF);
        set_req(1, 1'b0, 32'h1000, 64'h0);
        set_req(2, 1'b1, 32'h1010, 64'hFEDC_BA98_7654_3210);
        set_req(3, 1'b0, 32'h1008, 64'h0);
        gb    = gq.size();
        rereq = 1'b0;
        n     = 0;
        while (n < 60 && (t_act || p_vld != '0 || !rereq)) begin
            step();
            n++;
            if (!rereq && gq.size() > gb) begin
                set_req(0, 1'b0, 32'h1010, 64'h0);
                rereq = 1'b1;
            end
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("t3_count", 64'(gq.size() - gb), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (gb + k < gq.size()) chk("t3_order", 64'(gq[gb + k]), 64'(exp_order[k]));
        end

        // Misaligned write from requester 2
        wd4 = 64'h5555_AAAA_1234_9876;
        set_req(2, 1'b1, 32'h1005, wd4);
        drain("t4_timeout", 20);
        chk("t4_owner",    64'(rlog_owner[$]), 64'd2);
        chk("t4_err",      64'(rlog_err[$]),   64'h1);
        chk("t4_mem_addr", 64'(bus.mem_addr),  64'h1000);
        chk("t4_mem",      phys[0],            wd4);

        // Random traffic, occasional withdrawals and mem_ready gaps while idle
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)),
                            32'h1000 + 32'($urandom_range(0, 7)) * 8 +
                            (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 7)) : 32'h0),
                            {$urandom, $urandom});
                end else if (p_vld[i] && $urandom_range(0, 15) == 0) begin
                    p_vld[i] = 1'b0;
                end
            end
            bus.mem_ready = t_act ? 1'b1 : ($urandom_range(0, 7) != 0);
            step();
        end
        drain("rand_timeout", 60);

        // mem_ready low for five cycles starting in the read-wait cycle
        set_req(3, 1'b0, 32'h1000, 64'h0);
        exp5  = mm[0];
        got5  = 64'h0;
        acc_c = -100;
        rsp_c = -1;
        rsp_n = 0;
        other = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req_ready[3]) acc_c = c;
            if (bus.rsp_valid[3]) begin
                rsp_n++;
                rsp_c = c;
                got5  = bus.rsp_rdata;
            end
            if ((bus.rsp_valid & 4'b0111) != 4'b0000) other++;
            @(posedge clk);
            #1;
            if (c == acc_c) p_vld[3] = 1'b0;
            bus.mem_ready = !((c + 1) >= acc_c + 2 && (c + 1) <= acc_c + 6);
        end
        chk("t5_rsp_count", 64'(rsp_n),         64'd1);
        chk("t5_data",      got5,               exp5);
        chk("t5_latency",   64'(rsp_c - acc_c), 64'd9);
        chk("t5_other",     64'(other),         64'd0);
        chk("t5_idle",      64'(bus.busy),      64'h0);
        m_ptr = 0;

        // Reset asserted while a write sits in ISSUE
        set_req(1, 1'b1, 32'h1018, 64'hA5A5_5A5A_0F0F_F0F0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.req_ready[1]) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("t6_accept", 64'(seen), 64'h1);
        set_req(0, 1'b0, 32'h1000, 64'h0);
        set_req(1, 1'b1, 32'h1020, 64'h1111_2222_3333_4444);
        set_req(2, 1'b0, 32'h1018, 64'h0);
        set_req(3, 1'b1, 32'h1028, 64'h9999_8888_7777_6666);
        #2 rstn = 1'b0;
        #1;
        chk("t6_busy",      64'(bus.busy),      64'h0);
        chk("t6_mem_write", 64'(bus.mem_write), 64'h0);
        chk("t6_mem_mask",  64'(bus.mem_mask),  64'h0);
        chk("t6_mem_addr",  64'(bus.mem_addr),  64'h0);
        chk("t6_mem_wdata", bus.mem_wdata,      64'h0);
        chk("t6_rsp_rdata", bus.rsp_rdata,      64'h0);
        chk("t6_rsp_err",   64'(bus.rsp_err),   64'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'h0);
            chk("t6_req_ready", 64'(bus.req_ready), 64'h0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        chk("t6_aborted_write", phys[3], mm[3]);
        gb = gq.size();
        drain("t6_timeout", 60);
        if (gq.size() > gb) chk("t6_first_grant", 64'(gq[gb]), 64'd0);
        else                chk("t6_no_grant",    64'(gq.size() - gb), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
